// File: rtl/lsu_unit_if.sv
// Data-memory port of the load/store unit: registered request, byte enables and
// store data out; ack with read data back.
interface lsu_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_unit.sv
// RV32I load/store unit: checks legality, issues one req/ack memory access and
// returns aligned, sign/zero-extended load data; stalls the core while in flight.
module lsu_unit (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       rs2_data,
  output logic              lsu_busy,
  output logic              lsu_done,
  output logic [31:0]       load_data,
  output logic              lsu_fault,
  output logic [1:0]        fault_cause,
  lsu_unit_if.master        mem
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

  state_t      state_q, state_d;
  logic        start;
  logic [1:0]  cause_d, cause_q;
  logic [3:0]  be_d, be_q;
  logic [31:0] wdata_d, wdata_q;
  logic [31:0] addr_q;
  logic        we_q, req_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_d, load_q;

  assign start = ex_valid & (ex_load | ex_store);

  // Illegal encoding outranks misalignment; store wins when both flags are set.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cause_d = CAUSE_NONE;
    if (ex_store ? (funct3[2] | (funct3[1:0] == 2'b11))
                 : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11)))
      cause_d = CAUSE_ILLEGAL;
    else if (((funct3[1:0] == 2'b01) & alu_result[0]) |
             ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00)))
      cause_d = CAUSE_MISALGN;
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {alu_result[1], 1'b0};
        wdata_d = {2{rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset latched at accept time, not the live ALU bus.
  assign shifted  = mem.mem_rdata >> {off_q, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ext_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ext_d = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext_d = {24'h0, byte_sel};
      3'b101:  ext_d = {16'h0, half_sel};
      default: ext_d = mem.mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lsu_busy    = 1'b0;
    lsu_done    = 1'b0;
    lsu_fault   = 1'b0;
    fault_cause = CAUSE_NONE;
    case (state_q)
      IDLE: if (start) begin
        lsu_busy = 1'b1;
        state_d  = (cause_d != CAUSE_NONE) ? FAULT : REQ;
      end
      REQ: begin
        lsu_busy = 1'b1;
        if (mem.mem_ack) state_d = DONE;
      end
      DONE: begin
        lsu_done = 1'b1;
        state_d  = IDLE;
      end
      FAULT: begin
        lsu_done    = 1'b1;
        lsu_fault   = 1'b1;
        fault_cause = cause_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cause_q <= CAUSE_NONE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      load_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cause_q <= cause_d;
        if (cause_d == CAUSE_NONE) begin
          req_q   <= 1'b1;
          we_q    <= ex_store;
          addr_q  <= {alu_result[31:2], 2'b00};
          be_q    <= be_d;
          wdata_q <= wdata_d;
          f3_q    <= funct3;
          off_q   <= alu_result[1:0];
        end
      end
      if (state_q == REQ && mem.mem_ack) begin
        req_q <= 1'b0;
        if (!we_q) load_q <= ext_d;
      end
    end
  end

  assign load_data     = load_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;

endmodule
